unsaved_mem_stream_reader: RTL and testbench
============================================

Name: unsaved_mem_stream_reader

Overview:
- Read-side companion stage directly downstream of the 1024x32 single-port on-chip RAM.
- On a start command, issues sequential word reads to the RAM and presents the returned words as an Avalon-ST source with valid/ready backpressure, sop/eop framing and a done pulse.
- Absorbs the RAM's fixed 1-cycle read latency with a 2-entry output buffer, so throughput is 1 word/cycle when the sink is always ready.

Parameters:
- ADDR_W, 10, RAM word-address width; the address space is 2^ADDR_W words.
- DATA_W, 32, RAM and stream data width.
- LEN_W, 11, width of the length field; the maximum length is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address, latched on an accepted start.
- length  in  LEN_W  number of words to read, latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  RAM select; high only on read-issue cycles.
- mem_write  out  1  tied 0.
- mem_byteenable  out  4  tied 4'hF.
- mem_clken  out  1  tied 1.
- mem_readdata  in  DATA_W  RAM read data; valid the cycle after the address is issued.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  stream ready.
- st_sop  out  1  asserted with the first beat of a transfer.
- st_eop  out  1  asserted with the last beat of a transfer.

Behaviour:
- Reset (async, reset_n=0) values:
  - busy=0, done=0, st_valid=0, st_sop=0, st_eop=0, st_data=0.
  - mem_chipselect=0, mem_address=0.
  - State = IDLE; buffer empty; all counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and length!=0: latch base_addr and length; issue_cnt=0; beat_cnt=0; go to RUN.
  - start=1 and length==0: go directly to DONE; no RAM access and no beats.
- RUN, read issue:
  - A read issues in a cycle when issue_cnt<length AND (buffer_occupancy + inflight) < 2.
  - On issue: mem_chipselect=1; mem_address = base+issue_cnt, taken modulo 2^ADDR_W (wraps 1023 -> 0); issue_cnt increments.
  - inflight is 1 in the cycle after an issue. mem_readdata is written into the buffer in that cycle.
  - After issue_cnt reaches length, go to DRAIN.
- Buffer:
  - 2-entry FIFO; st_data and st_valid are driven from its head.
  - A beat transfers when st_valid && st_ready.
  - st_data/st_sop/st_eop must stay stable while st_valid && !st_ready.
  - A simultaneous push and pop is allowed; occupancy is unchanged.
  - The credit rule guarantees no overflow. An overflow is an assertion failure in simulation.
- Framing:
  - st_sop=1 on the beat with beat_cnt==0.
  - st_eop=1 on the beat with beat_cnt==length-1.
  - length==1 gives sop and eop on the same beat.
- DRAIN: no new issues. When the last beat transfers, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- busy is 1 in RUN and DRAIN only. A start that arrives while not in IDLE is ignored, not queued.
- Throughput: with st_ready held 1, the first beat is valid 2 cycles after the start cycle, one beat per cycle follows, and done comes 1 cycle after eop is accepted.
- Reset asserted mid-transfer: everything returns immediately to reset values and the buffer is flushed. No done pulse and no further RAM reads.

Test Plan:
- base=0x010, length=4, st_ready=1 -> mem_address 0x010..0x013 on consecutive cycles; 4 beats in consecutive cycles with data=RAM[0x010..0x013]; sop on beat 0, eop on beat 3; done once; busy low afterwards.
- base=0x3FE, length=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001; data is the matching wrapped words in that order.
- length=8, st_ready toggles 1,0,0,1 repeating -> st_data stable during every stall; no beat lost or duplicated; never more than 2 reads unacknowledged; eop exactly on beat 7.
- length=0 start -> done pulse 1 cycle after start; st_valid and mem_chipselect stay 0 throughout.
- length=1 -> a single beat with sop=eop=1; a second start asserted mid-transfer is ignored (total beats = 1).
- reset_n pulsed low during beat 2 of a length=6 transfer -> all outputs at reset values asynchronously; no done; a new start then completes normally.

Source files
------------

// File: rtl/unsaved_mem_stream_reader.sv
// Sequential RAM reader: issues word reads from base_addr and streams the
// returned words out as an Avalon-ST source with sop/eop framing.
module unsaved_mem_stream_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic              inflight;

    // 2-entry buffer; count includes only stored words, not the word in flight.
    logic [DATA_W-1:0] buf_mem [2];
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;

    logic              accept;
    logic              issue;
    logic              bypass;
    logic              pop;
    logic              push;
    logic              drop;
    logic              last_beat;
    logic              last_issue;
    logic [DATA_W-1:0] head_data;

    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    assign accept     = (state == S_IDLE) && start && (length != '0);
    // Credit rule: stored words plus the word in flight never exceed two.
    assign issue      = (state == S_RUN) && (issue_cnt < len_q) &&
                        ((count + {1'b0, inflight}) < 2'd2);
    assign last_issue = issue && ((issue_cnt + LEN_W'(1)) == len_q);

    // Fall-through head: with the buffer empty the returning word goes
    // straight to the stream, which saves a cycle of latency.
    assign bypass    = (count == 2'd0);
    assign st_valid  = !bypass || inflight;
    assign head_data = bypass ? mem_readdata : buf_mem[rd_ptr];
    assign pop       = st_valid && st_ready;
    assign push      = inflight && !(bypass && pop);
    assign drop      = pop && !bypass;
    assign last_beat = (beat_cnt == (len_q - LEN_W'(1)));

    assign st_data = st_valid ? head_data : '0;
    assign st_sop  = st_valid && (beat_cnt == '0);
    assign st_eop  = st_valid && last_beat;

    assign mem_chipselect = issue;
    assign mem_address    = base_q + issue_cnt[ADDR_W-1:0];

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) state_d = (length != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (last_issue) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && last_beat) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state    <= state_d;
            inflight <= issue;
            if (accept) begin
                base_q    <= base_addr;
                len_q     <= length;
                issue_cnt <= '0;
                beat_cnt  <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + LEN_W'(1);
                if (pop)   beat_cnt  <= beat_cnt + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (drop) rd_ptr <= ~rd_ptr;
            case ({push, drop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: buffer storage is not reset; st_data is gated by st_valid and the
    // pointers/count are reset, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr] <= mem_readdata;
    end

    overflow_check: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !drop && (count == 2'd2)));

endmodule

// File: tb/tb_unsaved_mem_stream_reader.sv
// Scoreboard bench for unsaved_mem_stream_reader: a RAM model answers reads,
// expected beats/addresses are queued at start and checked by a monitor.
module tb_unsaved_mem_stream_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready = 1'b1;
    logic              st_sop;
    logic              st_eop;

    unsaved_mem_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .mem_address(mem_address),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop)
    );

    always #5 clk = ~clk;

    // RAM model with one cycle of read latency.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_chipselect) mem_readdata <= ram[mem_address];

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    beat_t             exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issued = 0;
    int beats = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    int eop_cyc = 0;
    int done_cyc = 0;
    int ready_mode = 0;
    int phase = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Sink ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: st_ready = 1'b1;
                1: begin
                    st_ready = (phase == 0) || (phase == 3);
                    phase = (phase + 1) % 4;
                end
                default: st_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares read addresses and stream beats against the queues.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_sop = 1'b0;
    logic              prev_eop = 1'b0;

    initial begin
        beat_t             e;
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {st_valid, st_sop, st_eop, st_data},
                          {1'b1, prev_sop, prev_eop, prev_data});
                if (mem_chipselect) begin
                    issued++;
                    check("read_expected", 64'(addr_q.size() != 0), 1);
                    if (addr_q.size() != 0) begin
                        a = addr_q.pop_front();
                        check("read_addr", mem_address, a);
                    end
                    check("outstanding_le2", 64'((issued - beats) <= 2), 1);
                end
                if (st_valid && st_ready) begin
                    check("beat_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("beat_data", st_data, e.data);
                        check("beat_sop", st_sop, e.sop);
                        check("beat_eop", st_eop, e.eop);
                    end
                    if (st_sop) first_beat_cyc = cyc;
                    if (st_eop) eop_cyc = cyc;
                    last_beat_cyc = cyc;
                    beats++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = st_valid && !st_ready;
                prev_data  = st_data;
                prev_sop   = st_sop;
                prev_eop   = st_eop;
            end
        end
    end

    // Reference model: a transfer is len words from (base + i) mod DEPTH.
    task automatic issue_start(input int base, input int len, input bit expect_accept);
        beat_t e;
        int    a;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        length    = LEN_W'(len);
        start_cyc = cyc;
        if (expect_accept) begin
            for (int i = 0; i < len; i++) begin
                a = (base + i) % DEPTH;
                e.data = ram[a];
                e.sop  = (i == 0);
                e.eop  = (i == len - 1);
                addr_q.push_back(ADDR_W'(a));
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_pulse", 64'(done_cnt - d0), 1);
        check("busy_low_at_done", busy, 0);
        @(negedge clk);
        #1;
        check("done_one_cycle", {done, busy}, 0);
        check("done_count", 64'(done_cnt - d0), 1);
        check("scoreboard_drained", 64'(exp_q.size() + addr_q.size()), 0);
    endtask

    task automatic run_xfer(input int base, input int len, input int budget);
        int d0 = done_cnt;
        issue_start(base, len, 1'b1);
        wait_done(d0, budget);
    endtask

    initial begin
        int d0;
        int b0;
        int i0;
        int n;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;

        #12;
        check("reset_ctrl", {busy, done, st_valid, st_sop, st_eop, mem_chipselect}, 0);
        check("reset_data", st_data, 0);
        check("reset_addr", mem_address, 0);
        check("tied_mem_ctrl", {mem_write, mem_byteenable, mem_clken}, 6'b0_1111_1);
        #11;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic transfer with full throughput and latency checks.
        ready_mode = 0;
        run_xfer(32'h010, 4, 40);
        check("first_beat_latency", 64'(first_beat_cyc - start_cyc), 2);
        check("beats_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 3);
        check("done_after_eop", 64'(done_cyc - eop_cyc), 1);

        // Address wrap at the top of the RAM.
        run_xfer(32'h3FE, 4, 40);
        check("wrap_back_to_back", 64'(last_beat_cyc - first_beat_cyc), 3);

        // Backpressure pattern 1,0,0,1.
        ready_mode = 1;
        phase = 0;
        run_xfer(32'h123, 8, 100);
        ready_mode = 0;

        // Zero length: immediate done, no reads, no beats.
        i0 = issued;
        b0 = beats;
        run_xfer(32'h055, 0, 10);
        check("len0_done_latency", 64'(done_cyc - start_cyc), 1);
        check("len0_no_activity", 64'((issued - i0) + (beats - b0)), 0);

        // Length 1 with a second start while busy.
        d0 = done_cnt;
        b0 = beats;
        issue_start(32'h200, 1, 1'b1);
        issue_start(32'h300, 3, 1'b0);
        wait_done(d0, 20);
        repeat (6) @(negedge clk);
        check("len1_single_beat", 64'(beats - b0), 1);
        check("len1_single_done", 64'(done_cnt - d0), 1);

        // Reset during beat 2 of a 6-beat transfer.
        d0 = done_cnt;
        b0 = beats;
        issue_start(32'h0A0, 6, 1'b1);
        n = 0;
        while ((beats - b0) < 3 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_test_reached_beat2", 64'(beats - b0), 3);
        reset_n = 1'b0;
        #1;
        check("midreset_ctrl", {busy, done, st_valid, st_sop, st_eop, mem_chipselect}, 0);
        check("midreset_data", st_data, 0);
        check("midreset_addr", mem_address, 0);
        exp_q.delete();
        addr_q.delete();
        issued = 0;
        beats = 0;
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("midreset_no_done", 64'(done_cnt - d0), 0);
        check("midreset_idle", {busy, st_valid, mem_chipselect}, 0);
        run_xfer(32'h0A0, 6, 40);

        // Randomized transfers under random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 12; k++) begin
            int len = $urandom_range(1, 24);
            run_xfer($urandom_range(0, DEPTH - 1), len, len * 30 + 20);
        end

        // Maximum length, wrapping from a random base.
        ready_mode = 0;
        run_xfer($urandom_range(0, DEPTH - 1), DEPTH, DEPTH + 40);
        check("maxlen_back_to_back", 64'(last_beat_cyc - first_beat_cyc), DEPTH - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
